// File: rtl/uart_fifo_ctrl.sv
// Buffered UART sequencer: 16-deep TX and RX byte FIFOs with TX_EN/TX_STATUS
// load handshake and RX_EFF/RX_READ drain handshake toward the UART core.
module uart_fifo_ctrl #(
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  tx_wr,
    input  logic [7:0]            tx_data,
    output logic                  tx_full,
    output logic [DEPTH_LOG2:0]   tx_count,
    input  logic                  rx_rd,
    output logic [7:0]            rx_data,
    output logic                  rx_empty,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  rx_ovr,
    input  logic                  ovr_clr,
    output logic                  irq,
    output logic [7:0]            uart_txd,
    output logic                  uart_tx_en,
    input  logic                  uart_tx_status,
    input  logic [7:0]            uart_rxd,
    input  logic                  uart_rx_eff,
    output logic                  uart_rx_read
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned TW    = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT_LOW} rx_state_t;

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;

    logic [7:0]            tx_mem [DEPTH];
    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [TW-1:0]         to_cnt;

    logic tx_empty_c, rx_full_c;
    logic tx_push_c, tx_pop_c;
    logic rx_req_c, rx_push_c, rx_pop_c, rx_ovr_set_c;

    // Occupancy decode and FIFO-facing combinational outputs
    always_comb begin
        tx_full      = (tx_count == CW'(DEPTH));
        tx_empty_c   = (tx_count == '0);
        rx_full_c    = (rx_count == CW'(DEPTH));
        rx_empty     = (rx_count == '0);
        rx_data      = rx_empty ? 8'h00 : rx_mem[rx_rp];
        irq          = !rx_empty || rx_ovr;
        tx_push_c    = tx_wr && !tx_full;
        rx_pop_c     = rx_rd && !rx_empty;
        // a simultaneous pop frees the slot, so the incoming byte is kept
        rx_push_c    = rx_req_c && (!rx_full_c || rx_pop_c);
        rx_ovr_set_c = rx_req_c && rx_full_c && !rx_pop_c;
    end

    // TX FSM state register
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    // TX next-state; the FIFO pop happens on the edge that enters TX_LOAD
    always_comb begin
        tx_next  = tx_state;
        tx_pop_c = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty_c && uart_tx_status) begin
                    tx_next  = TX_LOAD;
                    tx_pop_c = 1'b1;
                end
            end
            TX_LOAD:      tx_next = TX_WAIT_BUSY;
            TX_WAIT_BUSY: begin
                if (!uart_tx_status)                  tx_next = TX_WAIT_DONE;
                else if (to_cnt == TW'(BUSY_TIMEOUT)) tx_next = TX_IDLE;
            end
            TX_WAIT_DONE: if (uart_tx_status) tx_next = TX_IDLE;
            default:      tx_next = TX_IDLE;
        endcase
    end

    // TX registered outputs and busy-wait timeout counter
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            uart_tx_en <= 1'b0;
            uart_txd   <= 8'h00;
            to_cnt     <= '0;
        end else begin
            uart_tx_en <= tx_pop_c;
            if (tx_pop_c) uart_txd <= tx_mem[tx_rp];
            if (tx_state == TX_WAIT_BUSY) to_cnt <= to_cnt + TW'(1);
            else                          to_cnt <= '0;
        end
    end

    // RX FSM state register
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    // RX next-state; a byte is captured on the edge that enters RX_ACK
    always_comb begin
        rx_next  = rx_state;
        rx_req_c = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (uart_rx_eff) begin
                    rx_next  = RX_ACK;
                    rx_req_c = 1'b1;
                end
            end
            RX_ACK:      rx_next = RX_WAIT_LOW;
            RX_WAIT_LOW: if (!uart_rx_eff) rx_next = RX_IDLE;
            default:     rx_next = RX_IDLE;
        endcase
    end

    // RX acknowledge pulse and sticky overrun (set beats clear)
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            uart_rx_read <= 1'b0;
            rx_ovr       <= 1'b0;
        end else begin
            uart_rx_read <= rx_req_c;
            if (rx_ovr_set_c) rx_ovr <= 1'b1;
            else if (ovr_clr) rx_ovr <= 1'b0;
        end
    end

    // FIFO pointers and occupancy counters
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
        end else begin
            if (tx_push_c) tx_wp <= tx_wp + DEPTH_LOG2'(1);
            if (tx_pop_c)  tx_rp <= tx_rp + DEPTH_LOG2'(1);
            case ({tx_push_c, tx_pop_c})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
            if (rx_push_c) rx_wp <= rx_wp + DEPTH_LOG2'(1);
            if (rx_pop_c)  rx_rp <= rx_rp + DEPTH_LOG2'(1);
            case ({rx_push_c, rx_pop_c})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the counters gate visibility
    always_ff @(posedge sysclk) begin
        if (tx_push_c) tx_mem[tx_wp] <= tx_data;
        if (rx_push_c) rx_mem[rx_wp] <= uart_rxd;
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl with a behavioural UART transmitter.
module tb_uart_fifo_ctrl;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_full;
    logic [4:0] tx_count;
    logic       rx_rd;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic [4:0] rx_count;
    logic       rx_ovr;
    logic       ovr_clr;
    logic       irq;
    logic [7:0] uart_txd;
    logic       uart_tx_en;
    logic       uart_tx_status;
    logic [7:0] uart_rxd;
    logic       uart_rx_eff;
    logic       uart_rx_read;

    int vectors = 0;
    int errors  = 0;

    // transmitter model state and pulse log
    int         cyc       = 0;
    logic       model_on  = 1'b0;
    logic       tx_hold   = 1'b0;
    int         busy      = 0;
    int         rise_cyc  = 0;
    logic       have_rise = 1'b0;
    int         n_pulse   = 0;
    logic [7:0] log_data [32];
    int         log_gap  [32];
    logic [7:0] e;

    uart_fifo_ctrl dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .tx_wr          (tx_wr),
        .tx_data        (tx_data),
        .tx_full        (tx_full),
        .tx_count       (tx_count),
        .rx_rd          (rx_rd),
        .rx_data        (rx_data),
        .rx_empty       (rx_empty),
        .rx_count       (rx_count),
        .rx_ovr         (rx_ovr),
        .ovr_clr        (ovr_clr),
        .irq            (irq),
        .uart_txd       (uart_txd),
        .uart_tx_en     (uart_tx_en),
        .uart_tx_status (uart_tx_status),
        .uart_rxd       (uart_rxd),
        .uart_rx_eff    (uart_rx_eff),
        .uart_rx_read   (uart_rx_read)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc = cyc + 1;

    // UART transmitter: busy for 20 cycles after each load, optional forced busy
    always begin
        @(negedge sysclk);
        #2;
        if (model_on) begin
            if (uart_tx_en) begin
                if (n_pulse < 32) begin
                    log_data[n_pulse] = uart_txd;
                    log_gap[n_pulse]  = have_rise ? (cyc - rise_cyc) : -1;
                end
                n_pulse        = n_pulse + 1;
                busy           = 20;
                uart_tx_status = 1'b0;
                have_rise      = 1'b0;
            end else if (tx_hold) begin
                uart_tx_status = 1'b0;
            end else if (busy > 0) begin
                busy = busy - 1;
                if (busy == 0) begin
                    uart_tx_status = 1'b1;
                    rise_cyc       = cyc;
                    have_rise      = 1'b1;
                end
            end else if (!uart_tx_status) begin
                uart_tx_status = 1'b1;
                rise_cyc       = cyc;
                have_rise      = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one RX_EFF handshake; returns with the RX FSM back in idle
    task automatic rx_event(input logic [7:0] b, input logic rd, input logic clr, input string tag);
        @(negedge sysclk);
        uart_rxd    = b;
        uart_rx_eff = 1'b1;
        rx_rd       = rd;
        ovr_clr     = clr;
        @(negedge sysclk);
        chk({tag, "_rx_read_hi"}, 32'(uart_rx_read), 32'd1);
        uart_rx_eff = 1'b0;
        rx_rd       = 1'b0;
        ovr_clr     = 1'b0;
        @(negedge sysclk);
        chk({tag, "_rx_read_lo"}, 32'(uart_rx_read), 32'd0);
        @(negedge sysclk);
    endtask

    initial begin
        // reset with random inputs
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sysclk);
            tx_wr          = 1'($urandom);
            tx_data        = 8'($urandom);
            rx_rd          = 1'($urandom);
            ovr_clr        = 1'($urandom);
            uart_tx_status = 1'($urandom);
            uart_rxd       = 8'($urandom);
            uart_rx_eff    = 1'($urandom);
        end
        @(negedge sysclk);
        tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0; ovr_clr = 1'b0;
        uart_rxd = 8'h00; uart_rx_eff = 1'b0; uart_tx_status = 1'b1;
        model_on = 1'b1;
        @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        chk("rst_tx_en",    32'(uart_tx_en),   32'd0);
        chk("rst_rx_read",  32'(uart_rx_read), 32'd0);
        chk("rst_txd",      32'(uart_txd),     32'd0);
        chk("rst_rx_ovr",   32'(rx_ovr),       32'd0);
        chk("rst_tx_full",  32'(tx_full),      32'd0);
        chk("rst_rx_empty", 32'(rx_empty),     32'd1);
        chk("rst_irq",      32'(irq),          32'd0);
        chk("rst_rx_data",  32'(rx_data),      32'd0);
        chk("rst_tx_count", 32'(tx_count),     32'd0);
        chk("rst_rx_count", 32'(rx_count),     32'd0);
        repeat (5) @(negedge sysclk);
        chk("rst_no_tx_en", 32'(n_pulse), 32'd0);

        // three TX bytes
        n_pulse = 0; have_rise = 1'b0;
        @(negedge sysclk); tx_wr = 1'b1; tx_data = 8'h55;
        @(negedge sysclk);
        chk("tx3_count_1", 32'(tx_count), 32'd1);
        chk("tx3_en_early", 32'(uart_tx_en), 32'd0);
        tx_data = 8'hA3;
        @(negedge sysclk);
        chk("tx3_en_first", 32'(uart_tx_en), 32'd1);
        chk("tx3_txd_first", 32'(uart_txd), 32'h55);
        tx_data = 8'h0F;
        @(negedge sysclk); tx_wr = 1'b0;
        for (int k = 0; k < 300 && n_pulse < 3; k++) @(negedge sysclk);
        repeat (40) @(negedge sysclk);
        chk("tx3_pulses", 32'(n_pulse), 32'd3);
        chk("tx3_byte0", 32'(log_data[0]), 32'h55);
        chk("tx3_byte1", 32'(log_data[1]), 32'hA3);
        chk("tx3_byte2", 32'(log_data[2]), 32'h0F);
        chk("tx3_gap1", 32'(log_gap[1]), 32'd2);
        chk("tx3_gap2", 32'(log_gap[2]), 32'd2);
        chk("tx3_count_end", 32'(tx_count), 32'd0);

        // TX full and pointer wrap
        tx_hold = 1'b1;
        repeat (2) @(negedge sysclk);
        n_pulse = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge sysclk);
            if (i == 15) begin
                chk("txf_full_15", 32'(tx_full), 32'd0);
                chk("txf_count_15", 32'(tx_count), 32'd15);
            end
            if (i == 16) begin
                chk("txf_full_16", 32'(tx_full), 32'd1);
                chk("txf_count_16", 32'(tx_count), 32'd16);
            end
            tx_wr = 1'b1;
            tx_data = 8'(i);
        end
        @(negedge sysclk);
        tx_wr = 1'b0;
        chk("txf_count_17", 32'(tx_count), 32'd16);
        chk("txf_no_send", 32'(n_pulse), 32'd0);
        tx_hold = 1'b0;
        for (int k = 0; k < 1000 && n_pulse < 16; k++) @(negedge sysclk);
        repeat (40) @(negedge sysclk);
        chk("txf_pulses", 32'(n_pulse), 32'd16);
        for (int i = 0; i < 16; i++) chk($sformatf("txf_byte%0d", i), 32'(log_data[i]), 32'(i));
        chk("txf_count_end", 32'(tx_count), 32'd0);

        // RX fill and overrun
        for (int i = 0; i < 16; i++) rx_event(8'(8'h80 + i), 1'b0, 1'b0, $sformatf("rxf%0d", i));
        chk("rxf_count", 32'(rx_count), 32'd16);
        chk("rxf_irq", 32'(irq), 32'd1);
        chk("rxf_empty", 32'(rx_empty), 32'd0);
        chk("rxf_ovr_pre", 32'(rx_ovr), 32'd0);
        chk("rxf_head", 32'(rx_data), 32'h80);
        rx_event(8'h90, 1'b0, 1'b0, "rxo");
        chk("rxo_ovr", 32'(rx_ovr), 32'd1);
        chk("rxo_head", 32'(rx_data), 32'h80);
        chk("rxo_count", 32'(rx_count), 32'd16);
        @(negedge sysclk); ovr_clr = 1'b1;
        @(negedge sysclk); ovr_clr = 1'b0;
        chk("rxo_clr", 32'(rx_ovr), 32'd0);
        rx_event(8'h92, 1'b0, 1'b1, "rxs");
        chk("rxs_set_wins", 32'(rx_ovr), 32'd1);
        @(negedge sysclk); ovr_clr = 1'b1;
        @(negedge sysclk); ovr_clr = 1'b0;
        chk("rxs_clr", 32'(rx_ovr), 32'd0);

        // simultaneous RX push and pop on a full FIFO
        rx_event(8'h91, 1'b1, 1'b0, "rxpp");
        chk("rxpp_count", 32'(rx_count), 32'd16);
        chk("rxpp_ovr", 32'(rx_ovr), 32'd0);
        chk("rxpp_head", 32'(rx_data), 32'h81);
        for (int i = 0; i < 16; i++) begin
            @(negedge sysclk);
            e = (i < 15) ? 8'(8'h81 + i) : 8'h91;
            chk($sformatf("rxd_pop%0d", i), 32'(rx_data), 32'(e));
            rx_rd = 1'b1;
        end
        @(negedge sysclk);
        rx_rd = 1'b0;
        chk("rxd_empty", 32'(rx_empty), 32'd1);
        chk("rxd_count", 32'(rx_count), 32'd0);
        chk("rxd_data0", 32'(rx_data), 32'd0);
        chk("rxd_irq", 32'(irq), 32'd0);

        // reset during TX_WAIT_DONE with 5 bytes queued
        n_pulse = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sysclk);
            tx_wr = 1'b1;
            tx_data = 8'(8'hA0 + i);
        end
        @(negedge sysclk); tx_wr = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("rmo_count_pre", 32'(tx_count), 32'd5);
        chk("rmo_pulse_pre", 32'(n_pulse), 32'd1);
        n_pulse = 0;
        reset = 1'b0;
        #1;
        chk("rmo_count_rst", 32'(tx_count), 32'd0);
        chk("rmo_txd_rst", 32'(uart_txd), 32'd0);
        chk("rmo_full_rst", 32'(tx_full), 32'd0);
        @(negedge sysclk); reset = 1'b1;
        repeat (60) @(negedge sysclk);
        chk("rmo_no_tx_en", 32'(n_pulse), 32'd0);
        chk("rmo_count_end", 32'(tx_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // hard stop if the sequence ever stalls
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
